// File: rtl/alu_share_arb_if.sv
// Bundle between alu_share_arb and its surroundings: two request channels, the shared ALU
// drive/sample pins and the tagged response channel.
interface alu_share_arb_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_srca;
  logic [WIDTH-1:0] req0_srcb;
  logic [2:0]       req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_srca;
  logic [WIDTH-1:0] req1_srcb;
  logic [2:0]       req1_ctrl;

  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_srca, req0_srcb, req0_ctrl,
    input  req1_valid, req1_srca, req1_srcb, req1_ctrl,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_srca, alu_srcb, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  // Requesters, ALU and response consumer side
  modport master (
    output req0_valid, req0_srca, req0_srcb, req0_ctrl,
    output req1_valid, req1_srca, req1_srcb, req1_ctrl,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_srca, alu_srcb, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one combinational ALU between two requesters;
// operands registered before the ALU, result registered before the tagged response.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant;
  logic             sel;
  logic             any_valid;
  logic             accept;

  logic [WIDTH-1:0] srca_p0;
  logic [WIDTH-1:0] srcb_p0;
  logic [2:0]       ctrl_p0;
  logic             id_p0;

  logic             vld_p1;
  logic             id_p1;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             err_p1;

  function automatic logic illegal_op(input logic [2:0] code);
    return code[2] & code[1];
  endfunction

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) sel = ~last_grant;
    else                                  sel = bus.req1_valid;
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.alu_srca   = '0;
    bus.alu_srcb   = '0;
    bus.alu_ctrl   = 3'b000;
    case (state_q)
      IDLE: begin
        bus.req0_ready = any_valid & ~sel;
        bus.req1_ready = any_valid & sel;
        if (any_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        bus.alu_srca = srca_p0;
        bus.alu_srcb = srcb_p0;
        bus.alu_ctrl = ctrl_p0;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      srca_p0    <= '0;
      srcb_p0    <= '0;
      ctrl_p0    <= 3'b000;
      id_p0      <= 1'b0;
      vld_p1     <= 1'b0;
      id_p1      <= 1'b0;
      result_p1  <= '0;
      zero_p1    <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      state_q <= state_d;

      // Stage p0: capture the granted operation
      if (accept) begin
        srca_p0    <= sel ? bus.req1_srca : bus.req0_srca;
        srcb_p0    <= sel ? bus.req1_srcb : bus.req0_srcb;
        ctrl_p0    <= sel ? bus.req1_ctrl : bus.req0_ctrl;
        id_p0      <= sel;
        last_grant <= sel;
      end

      // Stage p1: register the ALU outcome, masking it for illegal codes
      if (state_q == EXEC) begin
        vld_p1 <= 1'b1;
        id_p1  <= id_p0;
        if (illegal_op(ctrl_p0)) begin
          result_p1 <= '0;
          zero_p1   <= 1'b0;
          err_p1    <= 1'b1;
        end else begin
          result_p1 <= bus.alu_result;
          zero_p1   <= bus.alu_zero;
          err_p1    <= 1'b0;
        end
      end else if (state_q == RESP && bus.rsp_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = id_p1;
  assign bus.rsp_result = result_p1;
  assign bus.rsp_zero   = zero_p1;
  assign bus.rsp_err    = err_p1;

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbiter/sequencer sharing the single combinational ALU between two requesters, e.g. the execute stage and a branch/address helper unit.
- Each requester uses a valid/ready request channel. Results return on one shared response channel tagged with the requester ID.
- Round-robin grant on contention. Operands are registered before driving the ALU, and the result is registered before response.
- Sits beside the ALU: drives its SrcA/SrcB/ALUControl inputs and samples its ALUResult/Zero outputs.

Parameters:
WIDTH, 32, operand/result width; must match the ALU datapath width.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_srca  input  WIDTH  requester 0 operand A
req0_srcb  input  WIDTH  requester 0 operand B
req0_ctrl  input  3  requester 0 ALU operation code
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_srca  input  WIDTH  requester 1 operand A
req1_srcb  input  WIDTH  requester 1 operand B
req1_ctrl  input  3  requester 1 ALU operation code
alu_srca  output  WIDTH  to ALU SrcA
alu_srcb  output  WIDTH  to ALU SrcB
alu_ctrl  output  3  to ALU ALUControl
alu_result  input  WIDTH  from ALU ALUResult
alu_zero  input  1  from ALU Zero
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that issued this response
rsp_result  output  WIDTH  registered ALU result
rsp_zero  output  1  registered Zero flag
rsp_err  output  1  operation code was illegal (110/111)

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (reset==0 at a rising edge) forces:
  - state=IDLE, last_grant=1;
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0;
  - operand registers=0.
- Reset mid-operation abandons any captured or pending operation with no response.
- IDLE, grant selection (combinational):
  - only req0_valid asserted -> select 0;
  - only req1_valid asserted -> select 1;
  - both asserted -> select !last_grant.
- reqN_ready = (state==IDLE) && selected==N. Never both high. Both ready lines are 0 in EXEC and RESP.
- Ready depends on valid. Requesters must not make valid depend on ready.
- Accept (valid&&ready), registered:
  - capture srca/srcb/ctrl and id;
  - last_grant=id;
  - state -> EXEC.
- No request accepted -> stay IDLE.
- EXEC (exactly 1 cycle):
  - alu_srca/alu_srcb/alu_ctrl driven from the operand registers;
  - at the clock edge, rsp_result/rsp_zero/rsp_err/rsp_id are registered and state -> RESP.
- Illegal code (ctrl 110 or 111) in EXEC: rsp_err=1, rsp_result=0, rsp_zero=0. The ALU is still driven but its output is ignored.
- Legal code in EXEC: rsp_err=0, rsp_result=alu_result, rsp_zero=alu_zero. rsp_zero is 1 only for code 101 with equal operands, per ALU.
- ALU drive outside EXEC: alu_srca=0, alu_srcb=0, alu_ctrl=000 (add).
- RESP:
  - rsp_valid=1;
  - rsp_id/result/zero/err held stable until rsp_ready sampled high;
  - on handshake -> IDLE and rsp_valid=0 next cycle;
  - rsp_ready low -> hold indefinitely; no new request is accepted while holding.
- Latency and throughput:
  - accept at cycle T -> rsp_valid at T+2;
  - with rsp_ready tied high, the next accept is at T+3;
  - minimum 3 cycles per operation.
- Fairness: with both requesters continuously valid, grants strictly alternate. The first tie after reset goes to requester 0.
- Arithmetic is entirely in the ALU. The block adds no width conversion and does no sign handling.

Test Plan:
- Reset, then req0 alone with A=5, B=3, ctrl=000 -> req0_ready=1 at T; rsp_valid at T+2 with rsp_id=0, rsp_result=8, rsp_zero=0, rsp_err=0.
- req1 alone with A=7, B=7, ctrl=101 -> rsp_id=1, rsp_result=0, rsp_zero=1. Then req1 with A=7, B=2, ctrl=101 -> rsp_result=5, rsp_zero=0.
- Both valid continuously from reset, rsp_ready=1:
  - grant order is 0,1,0,1;
  - accepts spaced exactly 3 cycles apart;
  - req0_ready and req1_ready never simultaneously 1.
- Backpressure:
  - hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable and both ready lines 0 throughout;
  - rsp_ready=1 -> IDLE next cycle and a pending request is accepted that cycle.
- req0 with ctrl=110 and A=1, B=1 -> rsp_err=1, rsp_result=0, rsp_zero=0. A following legal ctrl=011 with A=0xF0, B=0x0F -> rsp_result=0xFF, rsp_err=0.
- Reset asserted in EXEC and again in RESP -> next cycle rsp_valid=0 and state IDLE. The next tie grants requester 0, and the abandoned operation is never responded to.
